// File: rtl/multicycle_control.sv
// multicycle_control
//   Registered multi-cycle control sequencer for the 9-bit core. Each
//   instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB), and every
//   datapath strobe is asserted only in the phase that owns it. The block
//   adds a memory ready handshake with timeout, halting at instruction
//   boundaries, and a saturating retired-instruction counter.
//
// Handshakes:
//   instr/instr_valid is a valid-only interface. The instruction is consumed
//   in FETCH on the cycle instr_valid is 1. instr must stay stable through
//   the following DECODE cycle, because that is where it is decoded.
//   mem_ready completes the access started in MEM on the cycle it is
//   sampled high. MemRead/MemWrite are held high until then.
//
// Ports:
//   clk, reset_n      clock and synchronous active-low reset
//   start             leaves IDLE or HALT; ignored while busy
//   instr, instr_valid opcode from instruction memory and its valid flag
//   mem_ready         data memory access complete
//   branch_flag       compare flag from the datapath
//   halt              stop at the retire of the current instruction
//   ir_load, pc_inc, pc_branch            IR / PC control
//   InstType .. ALUOp                     phase-gated datapath strobes
//   busy, done, err                       status (err is a sticky timeout)
//   retired                               saturating retire count
//   dbg_state                             current FSM state, for checkers
module multicycle_control #(
  parameter int OPW         = 4,
  parameter int MCODE       = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNTW        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [MCODE-1:0] instr,
  input  logic             instr_valid,
  input  logic             mem_ready,
  input  logic             branch_flag,
  input  logic             halt,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic [1:0]       InstType,
  output logic             BranchInst,
  output logic             MemRead,
  output logic             MemtoReg,
  output logic             MemWrite,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic [OPW-1:0]   ALUOp,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNTW-1:0]  retired,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef struct packed {
    logic [1:0]     inst_type;
    logic [OPW-1:0] alu_op;
    logic           alu_src;
    logic           is_load;
    logic           is_store;
    logic           is_branch;
    logic           no_wb;      // eq/lt: compare only, retire from EXEC
  } ctrl_t;

  // Unused ALUOp code: low nibble all ones, upper bits zero.
  localparam logic [OPW-1:0] OP_NONE = OPW'(4'hF);

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int              TW      = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0]   TO_LAST = TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
  localparam logic            TO_EN   = (MEM_TIMEOUT != 0);

  state_e            state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d;
  ctrl_t             dec;
  logic [TW-1:0]     wait_q, wait_d;
  logic              err_q, err_d;
  logic [CNTW-1:0]   retired_q, retired_d;
  logic              retire;
  logic              timeout_hit;

  // Combinational opcode decode.
  always_comb begin
    dec           = '0;
    dec.alu_op    = OP_NONE;
    dec.alu_src   = 1'b1;
    case (instr[MCODE-1:MCODE-2])
      2'b10: begin
        dec.inst_type = 2'b10;
        dec.alu_op    = OPW'(4'b0101);
      end
      2'b11: begin
        dec.inst_type = 2'b11;
        dec.alu_op    = OPW'(4'b0110);
      end
      default: begin
        case (instr[3:0])
          4'd2: begin
            dec.alu_src = 1'b0;
            dec.alu_op  = OPW'(instr[3:0]);
          end
          4'd3: begin
            dec.is_load = 1'b1;
            dec.alu_op  = OPW'(instr[3:0]);
          end
          4'd4: begin
            dec.is_store = 1'b1;
            dec.alu_op   = OPW'(instr[3:0]);
          end
          4'd5, 4'd6: dec.is_branch = 1'b1;   // bne behaves exactly like bt
          4'd13, 4'd14: begin
            dec.no_wb  = 1'b1;
            dec.alu_op = OPW'(instr[3:0]);
          end
          default: dec.alu_op = OPW'(instr[3:0]);
        endcase
      end
    endcase
  end

  // mem_ready in the same cycle takes priority over the timeout.
  assign timeout_hit = TO_EN && (wait_q == TO_LAST) && !mem_ready;

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    wait_d     = wait_q;
    err_d      = err_q;
    retired_d  = retired_q;
    retire     = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_branch  = 1'b0;
    InstType   = 2'b00;
    BranchInst = 1'b0;
    MemRead    = 1'b0;
    MemtoReg   = 1'b0;
    MemWrite   = 1'b0;
    ALUSrc     = 1'b1;
    RegWrite   = 1'b0;
    ALUOp      = OP_NONE;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_load = instr_valid;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl_d  = dec;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        ALUOp    = ctrl_q.alu_op;
        ALUSrc   = ctrl_q.alu_src;
        InstType = ctrl_q.inst_type;
        if (ctrl_q.is_load || ctrl_q.is_store) begin
          wait_d  = '0;
          state_d = S_MEM;
        end else if (ctrl_q.is_branch) begin
          BranchInst = 1'b1;
          pc_branch  = branch_flag;
          pc_inc     = !branch_flag;
          retire     = 1'b1;
        end else if (ctrl_q.no_wb) begin
          pc_inc = 1'b1;
          retire = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        ALUOp    = ctrl_q.alu_op;
        MemRead  = ctrl_q.is_load;
        MemWrite = ctrl_q.is_store;
        if (mem_ready) begin
          if (ctrl_q.is_store) begin
            pc_inc = 1'b1;
            retire = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          // Abandon the access without retiring; err stays set until reset.
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = ctrl_q.is_load;
        pc_inc   = 1'b1;
        retire   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Retire: count and pick FETCH or HALT; halt is only honoured here.
    if (retire) begin
      if (retired_q != '1) retired_d = retired_q + CNTW'(1);
      state_d = halt ? S_HALT : S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      wait_q    <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign done      = (state_q == S_HALT);
  assign err       = err_q;
  assign retired   = retired_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
  localparam int OPW   = 4;
  localparam int MCODE = 5;
  localparam int TO    = 4;
  localparam int CNTW  = 16;

  logic             clk = 1'b0;
  logic             reset_n, start, instr_valid, mem_ready, branch_flag, halt;
  logic [MCODE-1:0] instr;
  logic             ir_load, pc_inc, pc_branch, BranchInst, MemRead, MemtoReg;
  logic             MemWrite, ALUSrc, RegWrite, busy, done, err;
  logic [1:0]       InstType;
  logic [OPW-1:0]   ALUOp;
  logic [CNTW-1:0]  retired;
  logic [2:0]       dbg_state;

  multicycle_control #(.OPW(OPW), .MCODE(MCODE), .MEM_TIMEOUT(TO), .CNTW(CNTW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .instr(instr),
    .instr_valid(instr_valid), .mem_ready(mem_ready), .branch_flag(branch_flag),
    .halt(halt), .ir_load(ir_load), .pc_inc(pc_inc), .pc_branch(pc_branch),
    .InstType(InstType), .BranchInst(BranchInst), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .ALUOp(ALUOp), .busy(busy), .done(done), .err(err),
    .retired(retired), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int model_ret = 0;
  bit model_err = 1'b0;

  // Expected outputs for the cycle being checked
  logic       e_ir_load, e_pc_inc, e_pc_branch, e_branch, e_mem_read, e_memtoreg;
  logic       e_mem_write, e_alu_src, e_reg_write, e_busy, e_done, e_err;
  logic [1:0] e_inst_type;
  logic [3:0] e_alu_op;
  bit         mask_alu;   // ALU-side strobes are unconstrained in WB

  typedef enum int {K_WB, K_CMP, K_BR, K_LB, K_SB} kind_e;
  typedef enum int {END_FETCH, END_HALT, END_RESET} end_e;

  // Instruction class from the opcode map
  function automatic kind_e kind_of(input logic [4:0] op);
    if (op[4]) return K_WB;               // movr / movi
    case (op[3:0])
      4'd3:         return K_LB;
      4'd4:         return K_SB;
      4'd5, 4'd6:   return K_BR;
      4'd13, 4'd14: return K_CMP;
      default:      return K_WB;
    endcase
  endfunction

  // ALUOp: mov has fixed codes, branches have none, everything else is the opcode value
  function automatic logic [3:0] alu_of(input logic [4:0] op);
    if (op[4:3] == 2'b10) return 4'b0101;
    if (op[4:3] == 2'b11) return 4'b0110;
    if (op[3:0] == 4'd5 || op[3:0] == 4'd6) return 4'hF;
    return op[3:0];
  endfunction

  function automatic logic [1:0] type_of(input logic [4:0] op);
    return op[4] ? op[4:3] : 2'b00;
  endfunction

  function automatic logic src_of(input logic [4:0] op);
    return (op[4:3] != 2'b10 && op[4:3] != 2'b11 && op[3:0] == 4'd2) ? 1'b0 : 1'b1;
  endfunction

  task automatic exp_idle(input logic b, input logic d);
    e_ir_load = 0; e_pc_inc = 0; e_pc_branch = 0; e_inst_type = 2'b00;
    e_branch = 0; e_mem_read = 0; e_memtoreg = 0; e_mem_write = 0;
    e_alu_src = 1; e_reg_write = 0; e_alu_op = 4'hF;
    e_busy = b; e_done = d; e_err = model_err; mask_alu = 0;
  endtask

  task automatic check_outs(input string tag);
    logic [33:0] obs, expv;
    #1;
    obs  = {ir_load, pc_inc, pc_branch, mask_alu ? 2'b00 : InstType, BranchInst,
            MemRead, MemtoReg, MemWrite, mask_alu ? 1'b1 : ALUSrc, RegWrite,
            mask_alu ? 4'h0 : ALUOp, busy, done, err, retired};
    expv = {e_ir_load, e_pc_inc, e_pc_branch, mask_alu ? 2'b00 : e_inst_type, e_branch,
            e_mem_read, e_memtoreg, e_mem_write, mask_alu ? 1'b1 : e_alu_src, e_reg_write,
            mask_alu ? 4'h0 : e_alu_op, e_busy, e_done, e_err, CNTW'(model_ret)};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Inputs the design must ignore in the current phase
  task automatic rand_noise();
    start       = 1'($urandom_range(0, 1));
    halt        = 1'($urandom_range(0, 1));
    branch_flag = 1'($urandom_range(0, 1));
    mem_ready   = 1'($urandom_range(0, 1));
  endtask

  task automatic model_retire();
    if (model_ret < (1 << CNTW) - 1) model_ret++;
  endtask

  // Drives one instruction starting in FETCH, checking every cycle.
  // waits: MEM cycles with mem_ready low; rst_mem: MEM index where reset is applied.
  task automatic run_instr(input logic [4:0] op, input logic bf, input int waits,
                           input logic hlt, input int inval, input int rst_mem,
                           output end_e fin);
    kind_e k;
    logic  ret;
    k   = kind_of(op);
    fin = END_FETCH;
    for (int i = 0; i < inval; i++) begin
      @(negedge clk); rand_noise(); instr = 5'($urandom); instr_valid = 0;
      exp_idle(1, 0); check_outs("fetch_wait");
    end
    @(negedge clk); rand_noise(); instr = op; instr_valid = 1;
    exp_idle(1, 0); e_ir_load = 1; check_outs("fetch");
    @(negedge clk); rand_noise(); instr_valid = 1'($urandom_range(0, 1));
    exp_idle(1, 0); check_outs("decode");
    // EXEC: instr is no longer needed, scramble it
    @(negedge clk); rand_noise(); instr = 5'($urandom); branch_flag = bf;
    exp_idle(1, 0);
    e_alu_op = alu_of(op); e_alu_src = src_of(op); e_inst_type = type_of(op);
    ret = 0;
    if (k == K_BR) begin
      e_branch = 1; e_pc_branch = bf; e_pc_inc = !bf; ret = 1;
    end else if (k == K_CMP) begin
      e_pc_inc = 1; ret = 1;
    end
    if (ret) halt = hlt;
    check_outs("exec");
    if (ret) begin
      model_retire();
      fin = hlt ? END_HALT : END_FETCH;
      return;
    end
    if (k == K_LB || k == K_SB) begin
      for (int i = 0; i < TO; i++) begin
        logic rdy, tmo;
        @(negedge clk); rand_noise();
        rdy = (i >= waits);
        mem_ready = rdy;
        tmo = !rdy && (i == TO - 1);
        exp_idle(1, 0);
        e_alu_op = alu_of(op); e_mem_read = (k == K_LB); e_mem_write = (k == K_SB);
        ret = rdy && (k == K_SB);
        if (ret) begin e_pc_inc = 1; halt = hlt; end
        if (rst_mem == i) reset_n = 0;
        check_outs($sformatf("mem%0d", i));
        if (rst_mem == i) begin
          model_ret = 0; model_err = 0; fin = END_RESET; return;
        end
        if (tmo) begin
          model_err = 1; fin = END_HALT; return;
        end
        if (ret) begin
          model_retire(); fin = hlt ? END_HALT : END_FETCH; return;
        end
        if (rdy) break;
      end
    end
    @(negedge clk); rand_noise(); halt = hlt;
    exp_idle(1, 0); mask_alu = 1;
    e_reg_write = 1; e_memtoreg = (k == K_LB); e_pc_inc = 1;
    check_outs("wb");
    model_retire();
    fin = hlt ? END_HALT : END_FETCH;
  endtask

  // Sit in HALT for a few cycles, then restart into FETCH.
  task automatic halt_resume();
    int n;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); start = 0; halt = 1'($urandom_range(0, 1));
      exp_idle(0, 1); check_outs("halt");
    end
    @(negedge clk); start = 1;
    exp_idle(0, 1); check_outs("halt_start");
  endtask

  task automatic finish_instr(input end_e fin);
    if (fin == END_HALT) halt_resume();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    end_e fin;
    logic [4:0] op;
    reset_n = 0; start = 0; instr = '0; instr_valid = 0;
    mem_ready = 0; branch_flag = 0; halt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); exp_idle(0, 0); check_outs("reset");
    @(negedge clk); reset_n = 1; start = 0;
    exp_idle(0, 0); check_outs("idle_hold");
    @(negedge clk); start = 1; exp_idle(0, 0); check_outs("idle_start");

    // add, 4 cycles
    run_instr(5'b00000, 0, 0, 0, 0, -1, fin); finish_instr(fin);
    // lb with three not-ready MEM cycles (ready exactly at the timeout boundary)
    run_instr(5'b00011, 0, 3, 0, 1, -1, fin); finish_instr(fin);
    // bt taken, then not taken
    run_instr(5'b00101, 1, 0, 0, 0, -1, fin); finish_instr(fin);
    run_instr(5'b00101, 0, 0, 0, 0, -1, fin); finish_instr(fin);
    // movi then eq
    op = {2'b11, 3'($urandom)};
    run_instr(op, 0, 0, 0, 0, -1, fin); finish_instr(fin);
    run_instr(5'b01101, 0, 0, 0, 0, -1, fin); finish_instr(fin);
    // sb timing out: err set, HALT, nothing retired
    run_instr(5'b00100, 0, 9, 0, 0, -1, fin); finish_instr(fin);
    // err stays set across resume
    run_instr(5'b00001, 0, 0, 0, 0, -1, fin); finish_instr(fin);
    // halt requested in WB
    run_instr(5'b01000, 0, 0, 1, 0, -1, fin); finish_instr(fin);

    // Random instruction stream
    for (int n = 0; n < 60; n++) begin
      op = 5'($urandom);
      run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                1'($urandom_range(0, 5) == 0), $urandom_range(0, 2), -1, fin);
      finish_instr(fin);
    end

    // Reset during MEM of an lb: IDLE next cycle, counters cleared
    run_instr(5'b00011, 0, 3, 0, 0, 1, fin);
    @(negedge clk); reset_n = 1; start = 0; halt = 0;
    exp_idle(0, 0); check_outs("post_reset");
    @(negedge clk); start = 1; exp_idle(0, 0); check_outs("restart");
    run_instr(5'b00000, 0, 0, 0, 0, -1, fin); finish_instr(fin);
    @(negedge clk); rand_noise(); instr_valid = 0;
    exp_idle(1, 0); check_outs("final_fetch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
